mult_pipe_sgn: RTL and testbench
================================

Name: mult_pipe_sgn

Overview:
- Parametrised successor to the team's fixed 32x32 unsigned partial-product multiplier.
- Supports signed and unsigned operands and configurable width, with a valid/ready handshake.
- Uses a multi-cycle shift-add datapath, so one operation is in flight at a time.
- Sits beside the ALU in the multi-cycle CPU, serving MULT/MULTU and writing HI/LO through the {hi,lo} result.

Parameters:
- WIDTH, 32, operand width in bits; must be even and at least 4.
- RADIX_BITS, 1, multiplier bits retired per cycle; legal values are 1, 2 and 4; WIDTH must be divisible by RADIX_BITS.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous reset, active-high.
- start  in  1  request strobe; an operation is accepted when start && ready.
- sign  in  1  1 = signed (MULT), 0 = unsigned (MULTU); sampled at accept.
- a  in  WIDTH  multiplicand; sampled at accept.
- b  in  WIDTH  multiplier; sampled at accept.
- ready  out  1  high when idle and able to accept.
- busy  out  1  high while computing.
- done  out  1  one-cycle pulse when z is updated.
- z  out  2*WIDTH  product; holds its value until the next done.

Behaviour:
- Reset is asynchronous and active-high; clk is the single clock. While reset is high: state=IDLE, z=0, done=0, busy=0, ready=1, and all internal registers are 0.
- States: IDLE, CALC, FIX.
- IDLE:
  - ready=1.
  - On start, latch a, b and sign, then compute magnitudes:
    - If sign=1 and an operand's MSB is set, store its two's-complement magnitude in WIDTH+1 bits, so the most negative value is handled.
    - Record neg = sign & (a[MSB] ^ b[MSB]).
  - Clear the accumulator and step counter, then go to CALC.
  - The accept cycle does not count as a CALC cycle.
- CALC:
  - Each cycle, take the low RADIX_BITS of the remaining multiplier, k = mplier[RADIX_BITS-1:0].
  - Add k * (|a| << (cnt*RADIX_BITS)) into the 2*WIDTH+2-bit accumulator; k*|a| is formed by shift-adds only, with no * operator.
  - Shift mplier right by RADIX_BITS and increment cnt.
  - After WIDTH/RADIX_BITS cycles, go to FIX.
  - Early exit: if the remaining mplier is 0 before the last step, go to FIX on the next cycle. The early exit is mandatory.
- FIX:
  - z = neg ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0]; this is the two's-complement result truncated to 2*WIDTH bits.
  - done=1 for this cycle only; go to IDLE.
  - ready rises in the cycle after done.
- Latency, from the accept edge to the done cycle:
  - Full case: WIDTH/RADIX_BITS + 1 cycles (33 for the defaults).
  - b=0: 2 cycles.
- busy=1 in CALC and FIX, and busy = ~ready always.
- start while busy is ignored: no queuing and no effect on the running operation.
- start in the same cycle as done is not accepted, because ready=0; the requester holds start.
- z is never changed except in FIX, or cleared by reset.
- Reset mid-operation aborts immediately: z=0, and no done pulse is emitted for the aborted operation.
- Inputs a, b and sign may change after accept without affecting the result.
- Width rules:
  - The unsigned result is exact in 2*WIDTH bits.
  - The signed result is exact for all operand pairs, including (-2^(W-1))*(-2^(W-1)) = 2^(2W-2).

Test Plan:
- Reset then idle: reset pulsed mid-CALC of 7*9 -> z=0, ready=1, and no done pulse follows.
- Unsigned, WIDTH=32, RADIX_BITS=1: a=0xFFFFFFFF, b=0xFFFFFFFF, sign=0 -> z=0xFFFFFFFE00000001, done exactly 33 cycles after accept.
- Signed: a=0xFFFFFFFF (-1), b=0x00000005, sign=1 -> z=0xFFFFFFFFFFFFFFFB. Also a=0x80000000, b=0x80000000, sign=1 -> z=0x4000000000000000.
- Early exit: a=0x12345678, b=0 -> z=0, done 2 cycles after accept. Also b=1 -> z=0x12345678, done 2 cycles after accept.
- Handshake: start held through a running operation, and a/b changed mid-CALC -> the first result is unchanged; the second operation is accepted only in the cycle after done; exactly one done per accept.
- Parameter sweep: WIDTH=8 with RADIX_BITS=1, 2 and 4, all 2^16 operand pairs in both sign modes -> z matches the reference model; full-case latency is 9, 5 and 3 cycles respectively.

Source files
------------

// File: rtl/mult_pipe_sgn.sv
// Multi-cycle signed/unsigned shift-add multiplier with valid/ready handshake.
// Retires RADIX_BITS multiplier bits per cycle and exits early once the multiplier is exhausted.
module mult_pipe_sgn #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned RADIX_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 sign,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   z
);

  localparam int unsigned Steps = WIDTH / RADIX_BITS;
  localparam int unsigned CntW  = (Steps > 1) ? $clog2(Steps) : 1;
  localparam int unsigned AccW  = 2 * WIDTH + 2;

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e                state_q, state_d;
  logic [AccW-1:0]       acc_q, acc_d;
  logic [AccW-1:0]       mcand_q, mcand_d;
  logic [WIDTH:0]        mplier_q, mplier_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  neg_q, neg_d;
  logic [2*WIDTH-1:0]    z_q, z_d;

  logic [WIDTH:0]        abs_a, abs_b;
  logic [WIDTH:0]        mplier_shr;
  logic [RADIX_BITS-1:0] k;
  logic [AccW-1:0]       partial;
  logic [2*WIDTH-1:0]    acc_lo, fix_val;

  // W+1 bits so the most negative operand keeps its full magnitude.
  always_comb begin
    abs_a = {1'b0, a};
    abs_b = {1'b0, b};
    if (sign && a[WIDTH-1]) abs_a = {1'b0, ~a} + {{WIDTH{1'b0}}, 1'b1};
    if (sign && b[WIDTH-1]) abs_b = {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  end

  assign k          = mplier_q[RADIX_BITS-1:0];
  assign mplier_shr = mplier_q >> RADIX_BITS;

  // k * mcand built from shifted copies of the already-aligned multiplicand.
  always_comb begin
    partial = '0;
    for (int j = 0; j < int'(RADIX_BITS); j++) begin
      if (k[j]) partial = partial + (mcand_q << j);
    end
  end

  assign acc_lo  = acc_q[2*WIDTH-1:0];
  assign fix_val = neg_q ? (~acc_lo + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_lo;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    z_d      = z_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          neg_d    = sign & (a[WIDTH-1] ^ b[WIDTH-1]);
          mcand_d  = {{(AccW-WIDTH-1){1'b0}}, abs_a};
          mplier_d = abs_b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        acc_d    = acc_q + partial;
        mcand_d  = mcand_q << RADIX_BITS;
        mplier_d = mplier_shr;
        cnt_d    = cnt_q + {{(CntW-1){1'b0}}, 1'b1};
        // Leave as soon as no multiplier bits remain for later steps.
        if ((cnt_q == CntW'(Steps - 1)) || (mplier_shr == '0)) state_d = StFix;
      end
      StFix: begin
        z_d     = fix_val;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      z_q      <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      z_q      <= z_d;
    end
  end

  assign ready = (state_q == StIdle);
  assign busy  = ~ready;
  assign done  = (state_q == StFix);
  // The fixed-up product is visible during the done cycle and held afterwards.
  assign z     = done ? fix_val : z_q;

endmodule

// File: tb/tb_mult_pipe_sgn.sv
// Self-checking bench for mult_pipe_sgn: table vectors, handshake/reset sequences,
// and randomized 32-bit and 8-bit (radix 1/2/4) runs against an arithmetic model.
module tb_mult_pipe_sgn;

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] z;
    int          lat;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        start32, sign32;
  logic [31:0] a32, b32;
  logic        ready32, busy32, done32;
  logic [63:0] z32;

  logic        start8, sign8;
  logic [7:0]  a8, b8;
  logic        ready8 [3];
  logic        busy8  [3];
  logic        done8  [3];
  logic [15:0] z8     [3];

  int checks = 0;
  int errors = 0;
  int accepts = 0;
  int dones = 0;

  mult_pipe_sgn #(.WIDTH(32), .RADIX_BITS(1)) u_dut32 (
    .clk(clk), .reset(reset), .start(start32), .sign(sign32), .a(a32), .b(b32),
    .ready(ready32), .busy(busy32), .done(done32), .z(z32)
  );

  mult_pipe_sgn #(.WIDTH(8), .RADIX_BITS(1)) u_dut8_r1 (
    .clk(clk), .reset(reset), .start(start8), .sign(sign8), .a(a8), .b(b8),
    .ready(ready8[0]), .busy(busy8[0]), .done(done8[0]), .z(z8[0])
  );

  mult_pipe_sgn #(.WIDTH(8), .RADIX_BITS(2)) u_dut8_r2 (
    .clk(clk), .reset(reset), .start(start8), .sign(sign8), .a(a8), .b(b8),
    .ready(ready8[1]), .busy(busy8[1]), .done(done8[1]), .z(z8[1])
  );

  mult_pipe_sgn #(.WIDTH(8), .RADIX_BITS(4)) u_dut8_r4 (
    .clk(clk), .reset(reset), .start(start8), .sign(sign8), .a(a8), .b(b8),
    .ready(ready8[2]), .busy(busy8[2]), .done(done8[2]), .z(z8[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && start32 && ready32) accepts++;
    if (!reset && done32) dones++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Exact product truncated to 2*w bits.
  function automatic logic [63:0] ref_prod(input int w, input logic s,
                                           input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    logic [63:0] p;
    sx = longint'(x);
    sy = longint'(y);
    if (s && x[w-1]) sx = sx - (longint'(1) << w);
    if (s && y[w-1]) sy = sy - (longint'(1) << w);
    p = 64'(sx * sy);
    if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
    return p;
  endfunction

  // Cycles from accept to done: one per radix digit of |b| (at least one), plus the fix cycle.
  function automatic int ref_lat(input int w, input int r, input logic s, input logic [31:0] y);
    longint m;
    int bits, steps;
    m = longint'(y);
    if (s && y[w-1]) m = (longint'(1) << w) - m;
    bits = 0;
    while (m != 0) begin
      bits++;
      m = m >> 1;
    end
    steps = (bits + r - 1) / r;
    if (steps == 0) steps = 1;
    return steps + 1;
  endfunction

  task automatic wait_ready32();
    int n = 0;
    while (!ready32 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready32_wait", 64'(ready32), 64'd1);
  endtask

  task automatic run32(input string nm, input logic s, input logic [31:0] x,
                       input logic [31:0] y, input logic [63:0] ez, input int elat);
    int c;
    logic seen;
    wait_ready32();
    sign32 = s; a32 = x; b32 = y; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0; a32 = $urandom; b32 = $urandom; sign32 = 1'($urandom);
    c = 1;
    seen = 1'b0;
    while (c < 60 && !seen) begin
      if (done32) seen = 1'b1;
      else begin
        @(negedge clk);
        c++;
      end
    end
    chk({nm, "_done"}, 64'(seen), 64'd1);
    if (seen) begin
      chk({nm, "_z"}, z32, ez);
      chk({nm, "_lat"}, 64'(c), 64'(elat));
      chk({nm, "_ready_at_done"}, 64'(ready32), 64'd0);
      @(negedge clk);
      chk({nm, "_ready_after"}, 64'(ready32), 64'd1);
      chk({nm, "_z_hold"}, z32, ez);
      chk({nm, "_done_pulse"}, 64'(done32), 64'd0);
    end
  endtask

  task automatic run8(input logic s, input logic [7:0] x, input logic [7:0] y);
    int c, n;
    logic seen [3];
    int lat [3];
    logic [15:0] zr [3];
    logic [63:0] ez;
    n = 0;
    while (!(ready8[0] && ready8[1] && ready8[2]) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready8_wait", 64'(ready8[0] & ready8[1] & ready8[2]), 64'd1);
    sign8 = s; a8 = x; b8 = y; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sign8 = 1'($urandom);
    for (int i = 0; i < 3; i++) begin
      seen[i] = 1'b0; lat[i] = 0; zr[i] = '0;
    end
    c = 1;
    while (c < 20 && !(seen[0] && seen[1] && seen[2])) begin
      for (int i = 0; i < 3; i++) begin
        if (done8[i] && !seen[i]) begin
          seen[i] = 1'b1; lat[i] = c; zr[i] = z8[i];
        end
      end
      @(negedge clk);
      c++;
    end
    ez = ref_prod(8, s, {24'd0, x}, {24'd0, y});
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("w8r%0d_done s=%0d a=%h b=%h", 1 << i, s, x, y), 64'(seen[i]), 64'd1);
      chk($sformatf("w8r%0d_z s=%0d a=%h b=%h", 1 << i, s, x, y), 64'(zr[i]), ez);
      chk($sformatf("w8r%0d_lat s=%0d a=%h b=%h", 1 << i, s, x, y), 64'(lat[i]),
          64'(ref_lat(8, 1 << i, s, {24'd0, y})));
    end
  endtask

  vec_t vecs [8];

  initial begin
    int c, acc0, dn0;
    logic s;
    logic [31:0] x, y;

    vecs[0] = '{"u_max",      1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33};
    vecs[1] = '{"s_m1x5",     1'b1, 32'hFFFF_FFFF, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFFB, 4};
    vecs[2] = '{"s_minxmin",  1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 33};
    vecs[3] = '{"b_zero",     1'b0, 32'h1234_5678, 32'h0000_0000, 64'h0,                   2};
    vecs[4] = '{"b_one",      1'b0, 32'h1234_5678, 32'h0000_0001, 64'h0000_0000_1234_5678, 2};
    vecs[5] = '{"s_7xm3",     1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 3};
    vecs[6] = '{"s_maxxmin",  1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 33};
    vecs[7] = '{"u_msbxmsb",  1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 33};

    reset = 1'b1;
    start32 = 1'b0; sign32 = 1'b0; a32 = '0; b32 = '0;
    start8 = 1'b0; sign8 = 1'b0; a8 = '0; b8 = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_z", z32, 64'd0);
    chk("rst_ready", 64'(ready32), 64'd1);
    chk("rst_busy", 64'(busy32), 64'd0);
    chk("rst_done", 64'(done32), 64'd0);
    chk("rst_z8", 64'(z8[2]), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run32(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].z,
                            vecs[i].lat);

    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom);
      x = $urandom;
      case ($urandom_range(0, 3))
        0:       y = $urandom;
        1:       y = $urandom_range(0, 255);
        2:       y = 32'd0 - $urandom_range(0, 255);
        default: y = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
      endcase
      run32($sformatf("rnd32_%0d", i), s, x, y, ref_prod(32, s, x, y), ref_lat(32, 1, s, y));
    end

    // start held across a whole operation, operands swapped right after accept
    wait_ready32();
    acc0 = accepts;
    dn0 = dones;
    start32 = 1'b1; sign32 = 1'b0; a32 = 32'h0000_1000; b32 = 32'h0000_FFFF;
    @(negedge clk);
    a32 = 32'hFFFF_FFFE; b32 = 32'h0000_0003; sign32 = 1'b1;
    c = 1;
    while (c < 60 && !done32) begin
      @(negedge clk);
      c++;
    end
    chk("hs_op1_done", 64'(done32), 64'd1);
    chk("hs_op1_z", z32, 64'h0000_0000_0FFF_F000);
    chk("hs_op1_lat", 64'(c), 64'd17);
    chk("hs_ready_at_done", 64'(ready32), 64'd0);
    chk("hs_no_accept_while_busy", 64'(accepts - acc0), 64'd1);
    @(negedge clk);
    chk("hs_ready_after_done", 64'(ready32), 64'd1);
    @(negedge clk);
    start32 = 1'b0;
    c = 1;
    while (c < 60 && !done32) begin
      @(negedge clk);
      c++;
    end
    chk("hs_op2_done", 64'(done32), 64'd1);
    chk("hs_op2_z", z32, 64'hFFFF_FFFF_FFFF_FFFA);
    chk("hs_op2_lat", 64'(c), 64'd3);
    @(negedge clk);
    chk("hs_accepts", 64'(accepts - acc0), 64'd2);
    chk("hs_dones", 64'(dones - dn0), 64'd2);

    // reset in the middle of 7*9
    wait_ready32();
    start32 = 1'b1; sign32 = 1'b0; a32 = 32'd7; b32 = 32'd9;
    @(negedge clk);
    start32 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy_before_reset", 64'(busy32), 64'd1);
    dn0 = dones;
    reset = 1'b1;
    #1;
    chk("mid_rst_z", z32, 64'd0);
    chk("mid_rst_ready", 64'(ready32), 64'd1);
    chk("mid_rst_busy", 64'(busy32), 64'd0);
    chk("mid_rst_done", 64'(done32), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("mid_rst_no_done", 64'(dones - dn0), 64'd0);
    chk("mid_rst_z_after", z32, 64'd0);
    run32("post_rst_7x9", 1'b0, 32'd7, 32'd9, 64'd63, 5);

    run8(1'b0, 8'hFF, 8'hFF);
    run8(1'b1, 8'h80, 8'h80);
    run8(1'b1, 8'h80, 8'h7F);
    run8(1'b1, 8'h7F, 8'h80);
    run8(1'b1, 8'hFF, 8'hFF);
    run8(1'b0, 8'hAB, 8'h00);
    run8(1'b0, 8'h00, 8'hFF);
    run8(1'b1, 8'h05, 8'h01);
    for (int i = 0; i < 300; i++) run8(1'($urandom), 8'($urandom), 8'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
